// File: rtl/pc_predictor.sv
// Fetch-address generator: bimodal/gshare 2-bit direction table, return-address
// stack and a BOOT/WAIT/HOLD request sequencer driving a single-outstanding fetcher.
module pc_predictor #(
   parameter int unsigned IDX_BITS  = 10,
   parameter int unsigned GHR_BITS  = 0,
   parameter int unsigned RAS_DEPTH = 4,
   parameter logic [31:0] RESET_PC  = 32'h0
) (
   input  logic        in_clk,
   input  logic        in_rst,
   input  logic        in_rdy,
   input  logic        in_stall,
   input  logic        in_flush_enable,
   input  logic        in_feedback_enable,
   input  logic [31:0] in_commit_pc,
   input  logic        in_commit_taken,
   input  logic [31:0] in_redirect_pc,
   input  logic        in_fetch_valid,
   input  logic [31:0] in_fetch_pc,
   input  logic [31:0] in_fetch_inst,
   output logic        out_fetch_enable,
   output logic [31:0] out_fetch_pc,
   output logic        out_fetch_predict
);

   localparam int unsigned ENTRIES = 1 << IDX_BITS;
   localparam int unsigned PTR_W   = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned GHR_W   = (GHR_BITS > 0) ? GHR_BITS : 1;
   localparam logic [IDX_BITS-1:0] GHR_MASK = (GHR_BITS > 0) ? '1 : '0;

   typedef enum logic [1:0] {BOOT, WAIT, HOLD} state_t;

   state_t              state_q, state_d;
   logic [1:0]          pht_q [ENTRIES];
   logic [GHR_W-1:0]    ghr_q;
   logic [31:0]         ras_q [RAS_DEPTH];
   logic [PTR_W-1:0]    ras_ptr_q, ras_top;
   logic [CNT_W-1:0]    ras_cnt_q;
   logic [31:0]         held_q;
   logic                en_q, pred_q;
   logic [31:0]         pc_q;

   logic [IDX_BITS-1:0] ghr_idx, fetch_idx, commit_idx;
   logic                resp_ok, boot_issue, nxt_issue, latch;
   logic [31:0]         inst, b_imm, j_imm, nxt_pc;
   logic                nxt_pred, is_br, is_jal, is_ret, link_rd, push, pop;
   logic                unused_ok;

   assign unused_ok  = ^{in_commit_pc[31:IDX_BITS+2], in_commit_pc[1:0]};
   assign ghr_idx    = IDX_BITS'(ghr_q) & GHR_MASK;
   assign fetch_idx  = pc_q[IDX_BITS+1:2] ^ ghr_idx;
   assign commit_idx = in_commit_pc[IDX_BITS+1:2] ^ ghr_idx;
   assign ras_top    = ras_ptr_q - PTR_W'(1);

   assign out_fetch_enable  = en_q & in_rdy;
   assign out_fetch_pc      = pc_q;
   assign out_fetch_predict = pred_q;

   // The accepted instruction always belongs to the last issued pc, so pc_q is P.
   assign resp_ok = (state_q == WAIT) && in_fetch_valid && (in_fetch_pc == pc_q);
   assign inst    = (state_q == HOLD) ? held_q : in_fetch_inst;
   assign b_imm   = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
   assign j_imm   = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
   assign link_rd = (inst[11:7] == 5'd1) || (inst[11:7] == 5'd5);
   assign is_br   = inst[6:0] == 7'b1100011;
   assign is_jal  = inst[6:0] == 7'b1101111;
   assign is_ret  = (inst[6:0] == 7'b1100111) && (inst[11:7] == 5'd0) &&
                    ((inst[19:15] == 5'd1) || (inst[19:15] == 5'd5)) && (ras_cnt_q != '0);
   assign push    = is_jal && link_rd;
   assign pop     = is_ret;

   always_comb begin
      nxt_pc   = pc_q + 32'd4;
      nxt_pred = 1'b0;
      if (is_jal) begin
         nxt_pc   = pc_q + j_imm;
         nxt_pred = 1'b1;
      end else if (is_ret) begin
         nxt_pc   = ras_q[ras_top];
         nxt_pred = 1'b1;
      end else if (is_br && pht_q[fetch_idx][1]) begin
         nxt_pc   = pc_q + b_imm;
         nxt_pred = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      boot_issue = 1'b0;
      nxt_issue  = 1'b0;
      latch      = 1'b0;
      case (state_q)
         BOOT: if (!in_stall) begin
            boot_issue = 1'b1;
            state_d    = WAIT;
         end
         WAIT: if (resp_ok) begin
            if (!in_stall) nxt_issue = 1'b1;
            else begin
               latch   = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: if (!in_stall) begin
            nxt_issue = 1'b1;
            state_d   = WAIT;
         end
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         state_q   <= BOOT;
         en_q      <= 1'b0;
         pc_q      <= RESET_PC;
         pred_q    <= 1'b0;
         ras_ptr_q <= '0;
         ras_cnt_q <= '0;
         held_q    <= '0;
      end else if (!in_rdy) begin
         en_q <= 1'b0;
      end else begin
         en_q <= 1'b0;
         if (in_flush_enable) begin
            state_q   <= WAIT;
            en_q      <= 1'b1;
            pc_q      <= in_redirect_pc;
            pred_q    <= 1'b0;
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
         end else begin
            state_q <= state_d;
            if (latch) held_q <= in_fetch_inst;
            if (boot_issue) begin
               en_q   <= 1'b1;
               pc_q   <= RESET_PC;
               pred_q <= 1'b0;
            end
            if (nxt_issue) begin
               en_q   <= 1'b1;
               pc_q   <= nxt_pc;
               pred_q <= nxt_pred;
               // Full stack: pointer wraps onto the oldest entry, count pins at depth.
               if (push) begin
                  ras_ptr_q <= ras_ptr_q + PTR_W'(1);
                  if (ras_cnt_q != CNT_W'(RAS_DEPTH)) ras_cnt_q <= ras_cnt_q + CNT_W'(1);
               end else if (pop) begin
                  ras_ptr_q <= ras_top;
                  ras_cnt_q <= ras_cnt_q - CNT_W'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge in_clk) begin
      if (in_rdy && !in_flush_enable && nxt_issue && push)
         ras_q[ras_ptr_q] <= pc_q + 32'd4;
   end

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         for (int unsigned i = 0; i < ENTRIES; i++) pht_q[i] <= 2'b00;
         ghr_q <= '0;
      end else if (in_rdy && (in_flush_enable || in_feedback_enable)) begin
         if (in_commit_taken) begin
            if (pht_q[commit_idx] != 2'b11) pht_q[commit_idx] <= pht_q[commit_idx] + 2'b01;
         end else begin
            if (pht_q[commit_idx] != 2'b00) pht_q[commit_idx] <= pht_q[commit_idx] - 2'b01;
         end
         ghr_q <= (ghr_q << 1) | GHR_W'(in_commit_taken);
      end
   end

endmodule

// File: tb/tb_pc_predictor.sv
// Directed bench for pc_predictor: a vector table of single-instruction responses
// plus hand sequences for training, RAS, stall, flush, enable and async reset.
module tb_pc_predictor;

   logic        in_clk = 1'b0;
   logic        in_rst, in_rdy, in_stall, in_flush_enable, in_feedback_enable;
   logic [31:0] in_commit_pc, in_redirect_pc, in_fetch_pc, in_fetch_inst;
   logic        in_commit_taken, in_fetch_valid;
   logic        out_fetch_enable, out_fetch_predict;
   logic [31:0] out_fetch_pc;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] BEQ_M8   = 32'hFE00_0CE3;
   localparam logic [31:0] JAL0_40  = 32'h0400_006F;
   localparam logic [31:0] JAL1_40  = 32'h0400_00EF;
   localparam logic [31:0] JAL0_M4  = 32'hFFDF_F06F;
   localparam logic [31:0] RET      = 32'h0000_8067;
   localparam logic [31:0] JALR_X1  = 32'h0000_80E7;
   localparam logic [31:0] LW       = 32'h0000_2003;

   pc_predictor #(.IDX_BITS(10), .GHR_BITS(0), .RAS_DEPTH(4), .RESET_PC(32'h0)) dut (
      .in_clk(in_clk), .in_rst(in_rst), .in_rdy(in_rdy), .in_stall(in_stall),
      .in_flush_enable(in_flush_enable), .in_feedback_enable(in_feedback_enable),
      .in_commit_pc(in_commit_pc), .in_commit_taken(in_commit_taken),
      .in_redirect_pc(in_redirect_pc), .in_fetch_valid(in_fetch_valid),
      .in_fetch_pc(in_fetch_pc), .in_fetch_inst(in_fetch_inst),
      .out_fetch_enable(out_fetch_enable), .out_fetch_pc(out_fetch_pc),
      .out_fetch_predict(out_fetch_predict)
   );

   always #5 in_clk = ~in_clk;

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] exp_pc;
      logic        exp_pred;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge in_clk);
      #1;
   endtask

   task automatic check_issue(input string name, input logic [31:0] pc, input logic pred);
      check({name, ".en"},   32'(out_fetch_enable), 32'd1);
      check({name, ".pc"},   out_fetch_pc, pc);
      check({name, ".pred"}, 32'(out_fetch_predict), 32'(pred));
   endtask

   // commit_pc 0x3FC maps to an entry no test pc uses; not-taken keeps it at SNT.
   task automatic redirect(input logic [31:0] pc);
      in_flush_enable = 1'b1;
      in_redirect_pc  = pc;
      in_commit_pc    = 32'h3FC;
      in_commit_taken = 1'b0;
      tick();
      in_flush_enable = 1'b0;
      check_issue("redirect", pc, 1'b0);
   endtask

   task automatic respond(input string name, input logic [31:0] pc, input logic [31:0] inst,
                          input logic [31:0] exp_pc, input logic exp_pred);
      in_fetch_valid = 1'b1;
      in_fetch_pc    = pc;
      in_fetch_inst  = inst;
      tick();
      in_fetch_valid = 1'b0;
      check_issue(name, exp_pc, exp_pred);
   endtask

   task automatic feedback(input logic [31:0] pc, input logic taken);
      in_feedback_enable = 1'b1;
      in_commit_pc       = pc;
      in_commit_taken    = taken;
      tick();
      in_feedback_enable = 1'b0;
      check("feedback.no_pulse", 32'(out_fetch_enable), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] p;
      vecs[0] = '{"nop",        32'h0000_0010, NOP,     32'h0000_0014, 1'b0};
      vecs[1] = '{"beq_snt",    32'h0000_0100, BEQ_M8,  32'h0000_0104, 1'b0};
      vecs[2] = '{"jal_x0",     32'h0000_0300, JAL0_40, 32'h0000_0340, 1'b1};
      vecs[3] = '{"jal_neg",    32'h0000_0010, JAL0_M4, 32'h0000_000C, 1'b1};
      vecs[4] = '{"jal_wrap",   32'hFFFF_FFF0, JAL0_40, 32'h0000_0030, 1'b1};
      vecs[5] = '{"seq_wrap",   32'hFFFF_FFFC, NOP,     32'h0000_0000, 1'b0};
      vecs[6] = '{"ret_empty",  32'h0000_0400, RET,     32'h0000_0404, 1'b0};
      vecs[7] = '{"jalr_rd1",   32'h0000_0050, JALR_X1, 32'h0000_0054, 1'b0};
      vecs[8] = '{"load",       32'h0000_0060, LW,      32'h0000_0064, 1'b0};

      in_rst = 1'b1; in_rdy = 1'b1; in_stall = 1'b0;
      in_flush_enable = 1'b0; in_feedback_enable = 1'b0;
      in_commit_pc = '0; in_commit_taken = 1'b0; in_redirect_pc = '0;
      in_fetch_valid = 1'b0; in_fetch_pc = '0; in_fetch_inst = '0;
      #2;
      check("reset.en",   32'(out_fetch_enable), 32'd0);
      check("reset.pc",   out_fetch_pc, 32'h0);
      check("reset.pred", 32'(out_fetch_predict), 32'd0);
      #20;
      in_rst = 1'b0;
      tick();
      check_issue("boot", 32'h0, 1'b0);
      respond("first_nop", 32'h0, NOP, 32'h4, 1'b0);
      tick();
      check("pulse_one_cycle", 32'(out_fetch_enable), 32'd0);

      for (int i = 0; i < 9; i++) begin
         redirect(vecs[i].pc);
         respond(vecs[i].name, vecs[i].pc, vecs[i].inst, vecs[i].exp_pc, vecs[i].exp_pred);
      end

      // flush+feedback in one cycle counts once: SNT -> WNT
      in_flush_enable = 1'b1; in_feedback_enable = 1'b1;
      in_commit_pc = 32'h100; in_commit_taken = 1'b1; in_redirect_pc = 32'h100;
      tick();
      in_flush_enable = 1'b0; in_feedback_enable = 1'b0;
      check_issue("dual_update_redirect", 32'h100, 1'b0);
      respond("beq_wnt", 32'h100, BEQ_M8, 32'h104, 1'b0);
      feedback(32'h100, 1'b1);
      redirect(32'h100);
      respond("beq_wt", 32'h100, BEQ_M8, 32'hF8, 1'b1);
      feedback(32'h100, 1'b0);
      redirect(32'h100);
      respond("beq_back_wnt", 32'h100, BEQ_M8, 32'h104, 1'b0);

      redirect(32'h200);
      respond("call", 32'h200, JAL1_40, 32'h240, 1'b1);
      respond("ret", 32'h240, RET, 32'h204, 1'b1);
      respond("ret_again", 32'h204, RET, 32'h208, 1'b0);

      redirect(32'h500);
      in_stall = 1'b1;
      in_fetch_valid = 1'b1; in_fetch_pc = 32'h500; in_fetch_inst = NOP;
      tick();
      in_fetch_valid = 1'b0;
      check("stall.c1", 32'(out_fetch_enable), 32'd0);
      tick();
      check("stall.c2", 32'(out_fetch_enable), 32'd0);
      tick();
      check("stall.c3", 32'(out_fetch_enable), 32'd0);
      in_stall = 1'b0;
      tick();
      check_issue("stall_release", 32'h504, 1'b0);
      tick();
      check("stall.single", 32'(out_fetch_enable), 32'd0);
      in_fetch_valid = 1'b1; in_fetch_pc = 32'h508; in_fetch_inst = NOP;
      tick();
      in_fetch_valid = 1'b0;
      check("wrong_pc_ignored", 32'(out_fetch_enable), 32'd0);

      in_stall = 1'b1; in_flush_enable = 1'b1; in_redirect_pc = 32'h80;
      in_commit_pc = 32'h3FC; in_commit_taken = 1'b0;
      in_fetch_valid = 1'b1; in_fetch_pc = 32'h504; in_fetch_inst = JAL0_40;
      tick();
      in_stall = 1'b0; in_flush_enable = 1'b0; in_fetch_valid = 1'b0;
      check_issue("flush_stall", 32'h80, 1'b0);
      tick();
      check("flush_discard", 32'(out_fetch_enable), 32'd0);

      redirect(32'h600);
      in_rdy = 1'b0;
      in_fetch_valid = 1'b1; in_fetch_pc = 32'h600; in_fetch_inst = NOP;
      tick();
      check("rdy0.en", 32'(out_fetch_enable), 32'd0);
      tick();
      check("rdy0.pc", out_fetch_pc, 32'h600);
      in_rdy = 1'b1;
      tick();
      in_fetch_valid = 1'b0;
      check_issue("rdy_resume", 32'h604, 1'b0);

      redirect(32'h1000);
      p = 32'h1000;
      for (int i = 0; i < 5; i++) begin
         respond("nest_call", p, JAL1_40, p + 32'h40, 1'b1);
         p = p + 32'h40;
      end
      respond("nest_ret1", p, RET, 32'h1104, 1'b1);
      respond("nest_ret2", 32'h1104, RET, 32'h10C4, 1'b1);
      respond("nest_ret3", 32'h10C4, RET, 32'h1084, 1'b1);
      respond("nest_ret4", 32'h1084, RET, 32'h1044, 1'b1);
      respond("nest_ret5", 32'h1044, RET, 32'h1048, 1'b0);

      redirect(32'h2000);
      respond("pre_reset_call", 32'h2000, JAL1_40, 32'h2040, 1'b1);
      in_rst = 1'b1;
      #1;
      check("async_rst.en",   32'(out_fetch_enable), 32'd0);
      check("async_rst.pc",   out_fetch_pc, 32'h0);
      check("async_rst.pred", 32'(out_fetch_predict), 32'd0);
      #1;
      in_rst = 1'b0;
      tick();
      check_issue("reboot", 32'h0, 1'b0);
      respond("ret_after_rst", 32'h0, RET, 32'h4, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_predictor.md
PC_PREDICTOR -- requirements
Module: pc_predictor

Interface
REQ-001 SHALL have parameter IDX_BITS, default 10, log2 of pattern-table entries (2-bit counters).
REQ-002 SHALL have parameter GHR_BITS, default 0, global-history length (0 = bimodal indexing; max IDX_BITS).
REQ-003 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >=2).
REQ-004 SHALL have parameter RESET_PC, default 32'h0, first fetch address.
REQ-005 SHALL have port in_clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port in_rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port in_rdy  input  1  global enable; low freezes all state.
REQ-008 SHALL have port in_stall  input  1  downstream full; no new fetch issued.
REQ-009 SHALL have port in_flush_enable  input  1  committed mispredict; redirect.
REQ-010 SHALL have port in_feedback_enable  input  1  committed conditional branch, predicted correctly.
REQ-011 SHALL have port in_commit_pc  input  32  pc of committing branch.
REQ-012 SHALL have port in_commit_taken  input  1  actual direction of committing branch.
REQ-013 SHALL have port in_redirect_pc  input  32  correct next pc on flush.
REQ-014 SHALL have ports in_fetch_valid (1), in_fetch_pc (32), in_fetch_inst (32)  inputs  fetcher response.
REQ-015 SHALL have ports out_fetch_enable (1), out_fetch_pc (32), out_fetch_predict (1)  outputs  fetch request.

Function
REQ-016 SHALL keep 2^IDX_BITS counters: 00 SNT, 01 WNT, 10 WT, 11 ST; predict taken iff bit1=1.
REQ-017 SHALL index table with pc[IDX_BITS+1:2] XOR zero-extended committed GHR (GHR term omitted when GHR_BITS=0).
REQ-018 SHALL, on flush or feedback (once if both same cycle), saturating-increment counter if in_commit_taken else decrement, and shift in_commit_taken into GHR LSB.
REQ-019 SHALL use a state machine BOOT, WAIT, HOLD; reset state BOOT.
REQ-020 BOOT: when in_rdy & !in_stall, issue RESET_PC, predict 0, go WAIT.
REQ-021 WAIT: response accepted only when in_fetch_valid & in_fetch_pc==out_fetch_pc; others ignored; if !in_stall issue next pc in that cycle's edge, else latch inst, go HOLD.
REQ-022 HOLD: when !in_stall issue next pc from latched inst, go WAIT.
REQ-023 out_fetch_enable SHALL be a one-cycle pulse per issued request; 0 otherwise.
REQ-024 Next pc for accepted inst at pc P: opcode 1100011 -> P+B-imm if predicted taken (predict=1) else P+4; 1101111 (JAL) -> P+J-imm, predict=1; 1100111 (JALR) with rd=x0 and rs1 in {x1,x5} and RAS non-empty -> popped address, predict=1; all else P+4, predict=0.
REQ-025 JAL with rd in {x1,x5} SHALL push P+4; push on full RAS SHALL overwrite oldest (pointer wraps), count saturates at RAS_DEPTH.
REQ-026 Pop on empty RAS SHALL not occur (fall-through P+4, predict 0).
REQ-027 All pc arithmetic SHALL be 32-bit modulo 2^32.
REQ-028 Flush SHALL take priority over everything: next edge issues in_redirect_pc (enable=1, predict=0) regardless of in_stall, discards held inst, clears RAS count, state WAIT.
REQ-029 When in_rdy=0 no register SHALL change (table, GHR, RAS, state, outputs hold; enable forced 0).

Reset
REQ-030 On in_rst asserted, immediately: state BOOT, out_fetch_enable=0, out_fetch_pc=RESET_PC, out_fetch_predict=0, GHR=0, RAS empty, all counters SNT; mid-operation reset discards outstanding requests.

Verification
REQ-031 Reset, in_rdy=1 -> one pulse pc=0x0 predict=0; response inst 0x00000013 pc 0x0 -> pulse pc=0x4.
REQ-032 Response BEQ offset -8 at pc 0x100, table SNT -> pc 0x104 predict 0; after 2 taken flush/feedback updates at 0x100 (SNT->WNT->WT) -> pc 0xF8 predict 1.
REQ-033 JAL x1 +0x40 at 0x200 -> pc 0x240 predict 1; later JALR x0,0(x1) -> pc 0x204 predict 1; second JALR (RAS empty) -> P+4 predict 0.
REQ-034 Response arrives with in_stall=1 for 3 cycles -> no pulse, HOLD; stall drop -> single correct pulse.
REQ-035 Flush with in_redirect_pc=0x80 and in_stall=1 simultaneous with valid response -> next pulse pc 0x80 predict 0, response discarded.
REQ-036 RAS_DEPTH=4, five nested JAL x1 pushes then five returns -> four correct pops, fifth predicts P+4; async reset asserted mid-sequence -> outputs cleared without clock edge.
